// File: rtl/node_link_tx_if.sv
// Bundle of the request, neighbour link, response and result ports of node_link_tx.
// slave is the node_link_tx side; master is the controller/fabric side.
interface node_link_tx_if #(
  parameter int W = 2,
  parameter int N = 4
);
  localparam int S = (N > 1) ? $clog2(N) : 1;

  logic           req_valid;
  logic           req_ready;
  logic [W-1:0]   req_self;
  logic [N*W-1:0] req_nbr;
  logic           tx_valid;
  logic           tx_ready;
  logic [S-1:0]   tx_slot;
  logic [W-1:0]   tx_data;
  logic [W-1:0]   tx_self;
  logic           tx_last;
  logic           rsp_valid;
  logic           rsp_bit;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_mask;
  logic           out_err;
  logic           busy;

  modport slave (
    input  req_valid, req_self, req_nbr, tx_ready, rsp_valid, rsp_bit, out_ready,
    output req_ready, tx_valid, tx_slot, tx_data, tx_self, tx_last,
           out_valid, out_mask, out_err, busy
  );

  modport master (
    output req_valid, req_self, req_nbr, tx_ready, rsp_valid, rsp_bit, out_ready,
    input  req_ready, tx_valid, tx_slot, tx_data, tx_self, tx_last,
           out_valid, out_mask, out_err, busy
  );
endinterface

// File: rtl/node_link_tx.sv
// Serializes a node's neighbour values to the compare fabric one slot at a time
// and assembles the per-slot response bits into an N-bit mask.
module node_link_tx #(
  parameter int W   = 2,
  parameter int N   = 4,
  parameter int TMO = 15
) (
  input logic           clk,
  input logic           rst,
  node_link_tx_if.slave link
);
  localparam int S  = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO - 1);
  localparam logic [S-1:0]  SLOT_LAST = S'(N - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_self;
  logic [N*W-1:0] r_nbr;
  logic [S-1:0]   r_slot;
  logic [TW-1:0]  r_tmo;
  logic [N-1:0]   r_mask;
  logic           r_err;

  logic           r_req_ready;
  logic           r_tx_valid;
  logic [S-1:0]   r_tx_slot;
  logic [W-1:0]   r_tx_data;
  logic [W-1:0]   r_tx_self;
  logic           r_tx_last;
  logic           r_out_valid;
  logic [N-1:0]   r_out_mask;
  logic           r_out_err;
  logic           r_busy;

  logic           w_tmo_hit;
  logic           w_slot_done;
  logic [S-1:0]   w_slot_nxt;
  logic [N-1:0]   w_mask_upd;
  logic           w_err_upd;

  // Slot completion: a response in the final timeout cycle takes priority over the timeout.
  always_comb begin
    w_tmo_hit          = !link.rsp_valid && (r_tmo == TMO_LAST);
    w_slot_done        = link.rsp_valid || w_tmo_hit;
    w_slot_nxt         = (r_slot == SLOT_LAST) ? r_slot : r_slot + S'(1);
    w_mask_upd         = r_mask;
    w_mask_upd[r_slot] = link.rsp_valid & link.rsp_bit;
    w_err_upd          = r_err | w_tmo_hit;
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_self      <= '0;
      r_nbr       <= '0;
      r_slot      <= '0;
      r_tmo       <= '0;
      r_mask      <= '0;
      r_err       <= 1'b0;
      r_req_ready <= 1'b1;
      r_tx_valid  <= 1'b0;
      r_tx_slot   <= '0;
      r_tx_data   <= '0;
      r_tx_self   <= '0;
      r_tx_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
      r_out_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (link.req_valid) begin
            r_self      <= link.req_self;
            r_nbr       <= link.req_nbr;
            r_slot      <= '0;
            r_tmo       <= '0;
            r_mask      <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_tx_valid  <= 1'b1;
            r_tx_slot   <= '0;
            r_tx_data   <= link.req_nbr[W-1:0];
            r_tx_self   <= link.req_self;
            r_tx_last   <= (SLOT_LAST == '0);
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (link.tx_ready) begin
            r_tx_valid <= 1'b0;
            r_tmo      <= '0;
            r_state    <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (w_slot_done) begin
            r_mask <= w_mask_upd;
            r_err  <= w_err_upd;
            if (r_slot == SLOT_LAST) begin
              r_out_valid <= 1'b1;
              r_out_mask  <= w_mask_upd;
              r_out_err   <= w_err_upd;
              r_state     <= DONE;
            end else begin
              r_slot     <= w_slot_nxt;
              r_tx_valid <= 1'b1;
              r_tx_slot  <= w_slot_nxt;
              r_tx_data  <= r_nbr[w_slot_nxt*W +: W];
              r_tx_last  <= (w_slot_nxt == SLOT_LAST);
              r_state    <= SEND;
            end
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        DONE: begin
          if (link.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_tx_valid  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign link.req_ready = r_req_ready;
  assign link.tx_valid  = r_tx_valid;
  assign link.tx_slot   = r_tx_slot;
  assign link.tx_data   = r_tx_data;
  assign link.tx_self   = r_tx_self;
  assign link.tx_last   = r_tx_last;
  assign link.out_valid = r_out_valid;
  assign link.out_mask  = r_out_mask;
  assign link.out_err   = r_out_err;
  assign link.busy      = r_busy;
endmodule

// File: tb/tb_node_link_tx.sv
// Randomized bench for node_link_tx: a request-level model predicts beats, mask,
// error flag and end-to-end latency from each request's response plan.
module tb_node_link_tx;
  localparam int W   = 2;
  localparam int N   = 4;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst;

  node_link_tx_if #(.W(W), .N(N)) link ();
  node_link_tx #(.W(W), .N(N), .TMO(TMO)) dut (.clk(clk), .rst(rst), .link(link));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // request-level model state
  bit             m_active = 1'b0;
  int             m_next = 0;
  logic [W-1:0]   m_self;
  logic [N*W-1:0] m_nbr;
  logic [N-1:0]   m_exp_mask = '0;
  logic           m_exp_err = 1'b0;
  logic [N-1:0]   m_last_mask = '0;
  logic           m_last_err = 1'b0;
  int             t_acc = 0;
  int             t_out_hs = 0;

  bit             p_stall = 1'b0;
  logic [1:0]     p_slot;
  logic [W-1:0]   p_data;
  logic [W-1:0]   p_self;
  logic           p_last;

  // per-slot response plan: delay 0 = silent, 1..TMO = cycles after the beat
  int             pl_dly[N];
  int             pl_bp[N];
  logic           pl_bit[N];
  logic [W-1:0]   seen_data[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model bookkeeping on handshakes seen at the clock edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_active    <= 1'b0;
      m_next      <= 0;
      m_last_mask <= '0;
      m_last_err  <= 1'b0;
      p_stall     <= 1'b0;
    end else begin
      if (link.req_valid && link.req_ready) begin
        m_active <= 1'b1;
        m_next   <= 0;
        m_self   <= link.req_self;
        m_nbr    <= link.req_nbr;
        t_acc    <= cyc + 1;
      end
      if (link.tx_valid && link.tx_ready) m_next <= m_next + 1;
      if (link.out_valid && link.out_ready) begin
        m_active    <= 1'b0;
        m_last_mask <= m_exp_mask;
        m_last_err  <= m_exp_err;
        t_out_hs    <= cyc + 1;
      end
      p_stall <= link.tx_valid && !link.tx_ready;
      p_slot  <= link.tx_slot;
      p_data  <= link.tx_data;
      p_self  <= link.tx_self;
      p_last  <= link.tx_last;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", link.busy, m_active);
      chk("req_ready", link.req_ready, !m_active);
      if (!m_active) begin
        chk("tx_valid_idle", link.tx_valid, 1'b0);
        chk("out_valid_idle", link.out_valid, 1'b0);
      end
      if (p_stall) begin
        chk("tx_hold_valid", link.tx_valid, 1'b1);
        chk("tx_hold_slot", link.tx_slot, p_slot);
        chk("tx_hold_data", link.tx_data, p_data);
        chk("tx_hold_self", link.tx_self, p_self);
        chk("tx_hold_last", link.tx_last, p_last);
      end
      if (link.tx_valid) begin
        chk("tx_in_req", m_active && (m_next < N), 1'b1);
        if (m_next < N) begin
          chk("tx_slot", link.tx_slot, m_next);
          chk("tx_data", link.tx_data, m_nbr[m_next*W +: W]);
          chk("tx_self", link.tx_self, m_self);
          chk("tx_last", link.tx_last, m_next == N - 1);
        end
      end
      if (link.out_valid) begin
        chk("out_all_sent", m_next, N);
        chk("out_mask", link.out_mask, m_exp_mask);
        chk("out_err", link.out_err, m_exp_err);
      end else begin
        chk("out_mask_keep", link.out_mask, m_last_mask);
        chk("out_err_keep", link.out_err, m_last_err);
      end
    end
  end

  task automatic do_reset();
    link.req_valid = 1'b0;
    link.tx_ready  = 1'b0;
    link.rsp_valid = 1'b0;
    link.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, link.req_ready, 1'b1);
    chk({tag, "_tx_valid"}, link.tx_valid, 1'b0);
    chk({tag, "_tx_slot"}, link.tx_slot, 2'd0);
    chk({tag, "_tx_data"}, link.tx_data, 2'd0);
    chk({tag, "_tx_self"}, link.tx_self, 2'd0);
    chk({tag, "_tx_last"}, link.tx_last, 1'b0);
    chk({tag, "_out_valid"}, link.out_valid, 1'b0);
    chk({tag, "_out_mask"}, link.out_mask, 4'b0000);
    chk({tag, "_out_err"}, link.out_err, 1'b0);
    chk({tag, "_busy"}, link.busy, 1'b0);
  endtask

  task automatic plan_basic(input logic [W-1:0] self, input logic [N*W-1:0] nbr);
    for (int k = 0; k < N; k++) begin
      pl_dly[k] = 1;
      pl_bp[k]  = 0;
      pl_bit[k] = (nbr[k*W +: W] > self);
    end
  endtask

  // Drive one request through the link following the plan; rst_slot >= 0 aborts it by reset.
  task automatic run_req(input logic [W-1:0] self, input logic [N*W-1:0] nbr,
                         input int hold, input bit spur, input int rst_slot,
                         output int lat, output logic [N-1:0] got_mask, output logic got_err);
    int guard;
    int exp_lat;
    lat = -1;
    got_mask = '0;
    got_err = 1'b0;
    exp_lat = 1 + hold;
    m_exp_mask = '0;
    m_exp_err = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (pl_dly[k] >= 1 && pl_dly[k] <= TMO) begin
        m_exp_mask[k] = pl_bit[k];
        exp_lat += 1 + pl_bp[k] + pl_dly[k];
      end else begin
        m_exp_err = 1'b1;
        exp_lat += 1 + pl_bp[k] + TMO;
      end
    end
    if (spur) begin
      link.rsp_valid = 1'b1;
      link.rsp_bit   = 1'b1;
      @(negedge clk);
      link.rsp_valid = 1'b0;
    end
    guard = 0;
    while (!link.req_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!link.req_ready) begin
      chk("req_ready_wait", link.req_ready, 1'b1);
      do_reset();
      return;
    end
    link.req_valid = 1'b1;
    link.req_self  = self;
    link.req_nbr   = nbr;
    @(negedge clk);
    link.req_valid = 1'b0;
    link.req_self  = W'($urandom);
    link.req_nbr   = (N*W)'($urandom);
    for (int k = 0; k < N; k++) begin
      guard = 0;
      while (!link.tx_valid && guard < 64) begin
        @(negedge clk);
        guard++;
      end
      if (!link.tx_valid) begin
        chk("tx_valid_wait", link.tx_valid, 1'b1);
        do_reset();
        return;
      end
      seen_data[k] = link.tx_data;
      for (int b = 0; b < pl_bp[k]; b++) begin
        link.tx_ready  = 1'b0;
        link.rsp_valid = spur;
        link.rsp_bit   = ~m_exp_mask[k];
        @(negedge clk);
      end
      link.tx_ready  = 1'b1;
      link.rsp_valid = spur;
      link.rsp_bit   = ~m_exp_mask[k];
      @(negedge clk);
      link.tx_ready  = 1'b0;
      link.rsp_valid = 1'b0;
      if (k == rst_slot) begin
        repeat (3) @(negedge clk);
        do_reset();
        chk_reset_outputs("abort");
        repeat (3) @(negedge clk);
        return;
      end
      for (int j = 1; j <= TMO; j++) begin
        if (j == pl_dly[k]) begin
          link.rsp_valid = 1'b1;
          link.rsp_bit   = pl_bit[k];
        end
        @(negedge clk);
        link.rsp_valid = 1'b0;
        link.rsp_bit   = 1'($urandom);
        if (j == pl_dly[k]) break;
      end
    end
    guard = 0;
    while (!link.out_valid && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!link.out_valid) begin
      chk("out_valid_wait", link.out_valid, 1'b1);
      do_reset();
      return;
    end
    got_mask = link.out_mask;
    got_err  = link.out_err;
    for (int h = 0; h < hold; h++) begin
      link.out_ready = 1'b0;
      @(negedge clk);
      chk("out_hold_valid", link.out_valid, 1'b1);
    end
    link.out_ready = 1'b1;
    @(negedge clk);
    link.out_ready = 1'b0;
    lat = t_out_hs - t_acc;
    chk("latency", lat, exp_lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] nb;
    logic [N-1:0]   gm;
    logic           ge;
    int             lat;
    int             rs;
    logic [W-1:0]   basic_seq[N] = '{2'd1, 2'd2, 2'd0, 2'd3};

    link.req_valid = 1'b0;
    link.req_self  = '0;
    link.req_nbr   = '0;
    link.tx_ready  = 1'b0;
    link.rsp_valid = 1'b0;
    link.rsp_bit   = 1'b0;
    link.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    chk_reset_outputs("reset");

    nb = {2'd3, 2'd0, 2'd2, 2'd1};
    plan_basic(2'd1, nb);
    run_req(2'd1, nb, 0, 1'b0, -1, lat, gm, ge);
    chk("basic_mask", gm, 4'b1010);
    chk("basic_err", ge, 1'b0);
    chk("basic_lat", lat, 9);
    for (int k = 0; k < N; k++) chk("basic_data", seen_data[k], basic_seq[k]);

    plan_basic(2'd1, nb);
    pl_bp[1] = 3;
    run_req(2'd1, nb, 0, 1'b0, -1, lat, gm, ge);
    chk("bp_mask", gm, 4'b1010);
    chk("bp_lat", lat, 12);

    for (int k = 0; k < N; k++) begin
      pl_dly[k] = 1;
      pl_bp[k]  = 0;
      pl_bit[k] = 1'b1;
    end
    pl_dly[2] = 0;
    run_req(2'd1, nb, 0, 1'b0, -1, lat, gm, ge);
    chk("tmo_mask", gm, 4'b1011);
    chk("tmo_err", ge, 1'b1);
    chk("tmo_lat", lat, 23);

    for (int k = 0; k < N; k++) begin
      pl_dly[k] = 1;
      pl_bp[k]  = 0;
      pl_bit[k] = 1'b0;
    end
    pl_dly[0] = TMO;
    pl_bit[0] = 1'b1;
    run_req(2'd1, nb, 0, 1'b0, -1, lat, gm, ge);
    chk("coll_mask", gm, 4'b0001);
    chk("coll_err", ge, 1'b0);
    chk("coll_lat", lat, 23);

    plan_basic(2'd1, nb);
    pl_bp[2] = 2;
    run_req(2'd1, nb, 0, 1'b1, -1, lat, gm, ge);
    chk("spur_mask", gm, 4'b1010);
    chk("spur_lat", lat, 11);

    plan_basic(2'd1, nb);
    pl_dly[2] = 0;
    run_req(2'd1, nb, 0, 1'b0, 2, lat, gm, ge);
    plan_basic(2'd1, nb);
    run_req(2'd1, nb, 4, 1'b0, -1, lat, gm, ge);
    chk("post_rst_mask", gm, 4'b1010);
    chk("post_rst_lat", lat, 13);

    for (int r = 0; r < 40; r++) begin
      logic [W-1:0] sf;
      sf = W'($urandom);
      nb = (N*W)'($urandom);
      for (int k = 0; k < N; k++) begin
        int sel;
        sel = $urandom_range(0, 9);
        pl_dly[k] = (sel == 0) ? 0 : (sel == 1) ? TMO : $urandom_range(1, 5);
        pl_bp[k]  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
        pl_bit[k] = 1'($urandom);
      end
      rs = -1;
      if ($urandom_range(0, 9) == 0) begin
        rs = $urandom_range(0, N - 1);
        pl_dly[rs] = 0;
      end
      run_req(sf, nb, $urandom_range(0, 3), 1'($urandom), rs, lat, gm, ge);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/node_link_tx.md
Name: node_link_tx

Overview:
- Transmit side of the node neighbour interface.
- Accepts one request holding a node's own value and N neighbour values, then serializes the neighbour values to a comparator node one slot at a time over a valid/ready link.
- Collects the one-bit comparison response for each slot and assembles the N-bit result mask.
- Returns the mask to the requester on a valid/ready output port.
- Sits between the network controller and the node compare fabric.

Parameters:
W, 2, width of node and neighbour values
N, 4, neighbours per node; slot index width S = clog2(N), minimum 1
TMO, 15, maximum cycles spent waiting for a response before the slot is forced to 0

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_self  input  W  node's own value
req_nbr  input  N*W  neighbour values; slot k is bits [k*W +: W]
tx_valid  output  1  slot beat present on link
tx_ready  input  1  node accepts slot beat
tx_slot  output  S  current slot index
tx_data  output  W  neighbour value for current slot
tx_self  output  W  captured own value
tx_last  output  1  current slot is N-1
rsp_valid  input  1  response bit present
rsp_bit  input  1  comparison result for the outstanding slot
out_valid  output  1  mask available
out_ready  input  1  requester takes mask
out_mask  output  N  bit k = response for slot k
out_err  output  1  one or more slots timed out in this request
busy  output  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE and all registers clear.
  - req_ready=1 and all other outputs are 0, including out_mask and out_err.
  - Reset mid-operation abandons the transfer; no partial mask is emitted.
- States: IDLE, SEND, WAIT_RSP, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: capture req_self and req_nbr, clear the mask, err flag and slot counter, then go to SEND.
- SEND:
  - tx_valid=1; tx_slot = slot; tx_data = nbr[slot]; tx_self = the captured self value; tx_last = (slot==N-1).
  - Outputs hold stable until tx_ready.
  - On tx_valid&tx_ready: clear the timeout counter and go to WAIT_RSP.
- WAIT_RSP:
  - tx_valid=0.
  - On rsp_valid: mask[slot] <= rsp_bit.
  - If no rsp_valid and the timeout counter == TMO-1: mask[slot] <= 0 and err <= 1. Otherwise the counter increments.
  - On either completion: if slot==N-1, go to DONE; else slot++ and go to SEND.
  - If rsp_valid coincides with the timeout cycle, the response wins and err is not set.
- Ignored responses:
  - rsp_valid is ignored in any state other than WAIT_RSP.
  - This includes the cycle in which the SEND handshake occurs; the earliest response accepted is the following cycle.
- DONE:
  - out_valid=1; out_mask and out_err are held stable.
  - On out_ready: go to IDLE.
  - out_mask and out_err keep their last values after leaving DONE; they are only qualified by out_valid.
- req_ready=0 in all states except IDLE; req_valid outside IDLE is ignored.
- Latency (tx_ready=1, response one cycle after each beat, out_ready=1):
  - Request accepted at cycle 0.
  - Slot k beat at cycle 1+2k.
  - out_valid at cycle 2N+1 (cycle 9 for N=4).
  - Next request accepted at cycle 2N+2.
- Back-to-back: there is no overlap; a new request is taken only after DONE completes.
- The slot counter never wraps; it saturates at N-1 and is cleared only on request accept.

Test Plan:
- Basic:
  - Stimulus: self=2'b01, nbr={3,0,2,1} (slot3..slot0), tx_ready=1, bench responder returns (data>self) one cycle after each beat.
  - Required: tx_data sequence 1,2,0,3 on slots 0..3; tx_last only on slot 3; out_mask=4'b1010; out_err=0; out_valid at cycle 9.
- Link backpressure:
  - Stimulus: tx_ready held low 3 cycles on slot 1.
  - Required: tx_valid, tx_slot=1 and tx_data stay constant throughout; mask is unchanged versus the Basic case; out_valid is delayed by 3 cycles.
- Timeout:
  - Stimulus: responder silent for slot 2 and answers all other slots with 1, TMO=15.
  - Required: after 15 WAIT_RSP cycles the block moves to slot 3; out_mask=4'b1011; out_err=1.
- Response/timeout collision:
  - Stimulus: rsp_valid=1 with rsp_bit=1 exactly on cycle TMO-1 of WAIT_RSP.
  - Required: mask bit is 1 and out_err=0.
- Spurious and early responses:
  - Stimulus: rsp_valid pulses during IDLE, during SEND, and on the handshake cycle.
  - Required: all are ignored; final mask matches the Basic case.
- Reset and output hold:
  - Stimulus: rst asserted during WAIT_RSP of slot 2; then a new request; then out_ready held low 4 cycles in DONE.
  - Required: the cycle after rst, outputs are 0 and req_ready=1, with no out_valid from the aborted request; the new request completes normally; out_valid and out_mask stay stable for 4 cycles, then the block returns to IDLE.
